// File: rtl/phy_pkg.sv
// Shared phy definitions: receiver state encoding, comma symbol, default symbol width.
// Used by both the receive lanes and the phy transmitter.
package phy_pkg;

  localparam int PHY_DATA_WIDTH = 8;
  localparam logic [7:0] COMMA_SYM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_sipo.sv
// Serial-to-parallel front end: MSB-first shift register plus symbol bit counter.
// sym_done flags the edge that samples the last bit of a boundary-aligned symbol.
module phy_rx_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_8f,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  cnt_en,
  output logic [DATA_WIDTH-1:0] next_sreg,
  output logic                  sym_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;

  // Counter idles at 0 while no boundary is known, so the first counted bit is bit 0.
  always_comb begin
    sreg_d    = {sreg_q[DATA_WIDTH-2:0], serial_in};
    sym_done  = cnt_en && (bit_cnt_q == LAST_BIT);
    bit_cnt_d = '0;
    if (cnt_en && (bit_cnt_q != LAST_BIT)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  assign next_sreg = sreg_d;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/phy_rx_lane.sv
// Single-lane receiver: comma search, alignment lock, byte recovery every 8 clocks.
// Optional macro PHY_RX_STATS_EN adds the rx_byte_count saturating counter output.
module phy_rx_lane
  import phy_pkg::*;
#(
  parameter int                    DATA_WIDTH  = PHY_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] COMMA       = COMMA_SYM,
  parameter int                    COMMA_COUNT = 4
) (
  input  logic                  clk_8f,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  byte_stb,
`ifdef PHY_RX_STATS_EN
  output logic [15:0]           rx_byte_count,
`endif
  output logic                  active
);

  localparam logic [3:0] LOCK_CNT = COMMA_COUNT[3:0];

  rx_state_e             state_q, state_d;
  logic [3:0]            comma_cnt_q, comma_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  stb_q, stb_d;
  logic                  active_q, active_d;
  logic [DATA_WIDTH-1:0] next_sreg;
  logic                  sym_done;
  logic                  is_comma;

  phy_rx_sipo #(.DATA_WIDTH(DATA_WIDTH)) u_sipo (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .serial_in (serial_in),
    .cnt_en    (state_q != SEARCH),
    .next_sreg (next_sreg),
    .sym_done  (sym_done)
  );

  assign is_comma = (next_sreg == COMMA);

`ifdef PHY_RX_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d;
  assign rx_byte_count = rx_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    stb_d       = 1'b0;
`ifdef PHY_RX_STATS_EN
    rx_cnt_d    = rx_cnt_q;
`endif
    case (state_q)
      SEARCH: begin
        if (is_comma) begin
          comma_cnt_d = 4'd1;
          state_d     = (LOCK_CNT == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (sym_done) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_d == LOCK_CNT) begin
              state_d = ACTIVE;
            end
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Boundary is never revisited here; comma-like bit runs across symbols are data.
        if (sym_done) begin
          stb_d = 1'b1;
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = next_sreg;
            valid_d = 1'b1;
`ifdef PHY_RX_STATS_EN
            if (rx_cnt_q != 16'hFFFF) begin
              rx_cnt_d = rx_cnt_q + 16'd1;
            end
`endif
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q     <= SEARCH;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      active_q    <= 1'b0;
`ifdef PHY_RX_STATS_EN
      rx_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      stb_q       <= stb_d;
      active_q    <= active_d;
`ifdef PHY_RX_STATS_EN
      rx_cnt_q    <= rx_cnt_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: tb/tb_phy_rx_lane.sv
// Self-checking bench for phy_rx_lane: scenario tasks plus a byte scoreboard on byte_stb.
// Build with PHY_RX_STATS_EN to also cover rx_byte_count.
module tb_phy_rx_lane;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } exp_t;

  logic       clk_8f = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;
`ifdef PHY_RX_STATS_EN
  logic [15:0] rx_byte_count;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   stb_seen = 0;
  exp_t exp_q[$];
  logic [7:0] last_data = 8'h00;

  phy_rx_lane dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
`ifdef PHY_RX_STATS_EN
    .rx_byte_count (rx_byte_count),
`endif
    .active    (active)
  );

  always #5 clk_8f = ~clk_8f;

  // Scoreboard consumer: every strobe must match the oldest expected symbol.
  always @(negedge clk_8f) begin
    if (byte_stb === 1'b1) begin
      exp_t e;
      stb_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_stb: got data=%h valid=%b, expected no strobe", data_out, valid_out);
      end else begin
        e = exp_q.pop_front();
        if ({valid_out, data_out} !== {e.valid, e.data}) begin
          n_fail++;
          $display("FAIL sb_byte: got valid=%b data=%h, expected valid=%b data=%h",
                   valid_out, data_out, e.valid, e.data);
        end else begin
          $display("byte: valid=%b data=%h", valid_out, data_out);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_sym(input logic [7:0] sym);
    for (int i = 7; i >= 0; i--) send_bit(sym[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_8f);
    #1;
    reset = 1'b0;
    last_data = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      serial_in = 1'($urandom_range(0, 1));
      @(posedge clk_8f);
      #1;
      n_checks++;
      if ({data_out, valid_out, byte_stb, active} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got data=%h valid=%b stb=%b active=%b, expected all 0",
                 data_out, valid_out, byte_stb, active);
      end
    end
    reset = 1'b0;
    last_data = 8'h00;
    send_sym(8'hBC);
    send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_two_commas: got active=%b, expected 0", active);
    end
    $display("test_reset done");
  endtask

  task automatic test_lock();
    logic [7:0] c = 8'hBC;
    do_reset();
    for (int k = 0; k < 3; k++) send_sym(8'hBC);
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: got active=%b before last comma bit, expected 0", active);
    end
    send_bit(c[0]);
    n_checks++;
    if ({active, byte_stb} !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_edge: got active=%b stb=%b, expected active=1 stb=0", active, byte_stb);
    end
    $display("test_lock done");
  endtask

  task automatic test_misaligned();
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    for (int k = 0; k < 3; k++) send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_3rd: got active=%b, expected 0", active);
    end
    send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_lock: got active=%b, expected 1", active);
    end
    exp_q.push_back('{valid: 1'b0, data: last_data});
    send_sym(8'hBC);
    $display("test_misaligned done");
  endtask

  task automatic test_align_abort();
    do_reset();
    send_sym(8'hBC);
    send_sym(8'hBC);
    send_sym(8'h3C);
    for (int k = 0; k < 3; k++) send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_relock_early: got active=%b after 3 commas, expected 0", active);
    end
    send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_lock: got active=%b, expected 1", active);
    end
    $display("test_align_abort done");
  endtask

  task automatic test_data();
    logic [7:0] s;
    int stb0 = stb_seen;
    exp_q.push_back('{valid: 1'b1, data: 8'hA5});
    last_data = 8'hA5;
    send_sym(8'hA5);
    n_checks++;
    if ({valid_out, data_out} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL data_a5: got valid=%b data=%h, expected 1 a5", valid_out, data_out);
    end
    s = 8'hBC;
    exp_q.push_back('{valid: 1'b0, data: last_data});
    for (int i = 7; i >= 0; i--) begin
      send_bit(s[i]);
      if (i != 0) begin
        n_checks++;
        if ({valid_out, data_out} !== {1'b1, 8'hA5}) begin
          n_fail++;
          $display("FAIL data_hold_a5: got valid=%b data=%h, expected 1 a5", valid_out, data_out);
        end
      end
    end
    n_checks++;
    if ({valid_out, data_out} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL data_idle: got valid=%b data=%h, expected 0 a5", valid_out, data_out);
    end
    s = 8'h5A;
    exp_q.push_back('{valid: 1'b1, data: 8'h5A});
    last_data = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      send_bit(s[i]);
      if (i != 0) begin
        n_checks++;
        if (valid_out !== 1'b0) begin
          n_fail++;
          $display("FAIL data_hold_idle: got valid=%b, expected 0", valid_out);
        end
      end
    end
    n_checks++;
    if ({valid_out, data_out} !== {1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL data_5a: got valid=%b data=%h, expected 1 5a", valid_out, data_out);
    end
    #5;
    n_checks++;
    if (stb_seen - stb0 !== 3) begin
      n_fail++;
      $display("FAIL data_stb_count: got %0d strobes, expected 3", stb_seen - stb0);
    end
`ifdef PHY_RX_STATS_EN
    n_checks++;
    if (rx_byte_count !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_count: got %0d, expected 2", rx_byte_count);
    end
`endif
    $display("test_data done");
  endtask

  task automatic test_no_realign();
    exp_q.push_back('{valid: 1'b1, data: 8'h0B});
    exp_q.push_back('{valid: 1'b1, data: 8'hC0});
    last_data = 8'hC0;
    send_sym(8'h0B);
    send_sym(8'hC0);
    n_checks++;
    if ({active, valid_out, data_out} !== {1'b1, 1'b1, 8'hC0}) begin
      n_fail++;
      $display("FAIL no_realign: got active=%b valid=%b data=%h, expected 1 1 c0",
               active, valid_out, data_out);
    end
    $display("test_no_realign done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    @(posedge clk_8f);
    #1;
    reset = 1'b0;
    last_data = 8'h00;
    n_checks++;
    if ({data_out, valid_out, byte_stb, active} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got data=%h valid=%b stb=%b active=%b, expected all 0",
               data_out, valid_out, byte_stb, active);
    end
`ifdef PHY_RX_STATS_EN
    n_checks++;
    if (rx_byte_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_stats: got %0d, expected 0", rx_byte_count);
    end
`endif
    for (int k = 0; k < 3; k++) send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_early: got active=%b, expected 0", active);
    end
    send_sym(8'hBC);
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got active=%b, expected 1", active);
    end
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending bytes, expected 0", exp_q.size());
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_misaligned();
    test_align_abort();
    test_data();
    test_no_realign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane.md
Name: phy_rx_lane

Overview:
Single-lane serial receiver that consumes one serial stream from the phy transmitter (data_outS0 or data_outS1) and rebuilds the 8-bit data and valid signals.
- Finds the byte boundary by bit-level search for the comma (idle) symbol.
- Declares lock after a run of boundary-aligned commas.
- Then emits one byte every 8 clocks. Comma bytes are treated as idle.
- Two instances, one per lane, form the receive side of the phy.

Parameters:
DATA_WIDTH, 8, symbol width in bits; serial order MSB first.
COMMA, 8'hBC, idle/alignment symbol sent by the transmitter when valid is low.
COMMA_COUNT, 4, consecutive aligned commas required to enter ACTIVE (legal range 1..15).

Ports:
clk_8f  input  1  bit clock, one serial bit per rising edge
reset  input  1  synchronous, active-high reset
serial_in  input  1  serial bit stream, MSB of each symbol first
data_out  output  DATA_WIDTH  last received non-comma byte
valid_out  output  1  high while data_out holds a byte from the current symbol period
byte_stb  output  1  one-cycle pulse on each completed symbol while ACTIVE
active  output  1  lane locked (state ACTIVE)

Behaviour:
- Clocking and reset: all state updates on the rising edge of clk_8f. Reset is synchronous, active-high; polarity and synchronicity are fixed.
- Reset values: data_out=0, valid_out=0, byte_stb=0, active=0, shift register=0, bit_cnt=0, comma_cnt=0, state=SEARCH.
- Shift register: next_sreg = {sreg[6:0], serial_in}. Every decision below uses next_sreg, so a symbol is recognised on the same edge its last bit is sampled.
- State SEARCH: checked every cycle, no boundary assumed.
  - next_sreg==COMMA -> ALIGN, comma_cnt=1, bit_cnt=0 (boundary established).
- State ALIGN: bit_cnt counts 0..7; a symbol completes when bit_cnt==7, then bit_cnt wraps to 0.
  - Completed symbol ==COMMA: comma_cnt+1. If comma_cnt reaches COMMA_COUNT -> ACTIVE, active=1 on that edge.
  - Completed symbol !=COMMA -> SEARCH, comma_cnt=0.
  - COMMA_COUNT==1: go to ACTIVE directly from SEARCH on the first match.
- State ACTIVE: sticky until reset; the boundary is kept.
  - At each completed symbol: byte_stb=1 for that cycle.
  - Symbol !=COMMA: data_out=symbol, valid_out=1.
  - Symbol ==COMMA: valid_out=0, data_out holds its previous value.
  - valid_out is held constant for the full 8-cycle symbol period.
- Latency: data_out/valid_out update on the edge that samples the symbol's LSB.
- Comma-like patterns spanning two data symbols in ACTIVE are ignored; there is no realignment.
- Reset asserted mid-operation (any state, any bit_cnt): all outputs and state return to reset values on that edge; the partial symbol is discarded.
- Outputs are driven only from registers.

Optional Feature:
Macro PHY_RX_STATS_EN.
- Defined: adds output rx_byte_count [15:0]. It counts symbols received in ACTIVE with valid_out=1, increments on the same edge as that update, saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package phy_pkg holds:
  - state encoding: SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2
  - COMMA_SYM=8'hBC
  - DATA_WIDTH default
  - the phy_tx side uses the same package.
- One natural sub-module, phy_rx_sipo: the shift register plus bit counter, with a boundary-complete flag.
- The FSM, comma counter and output registers stay in phy_rx_lane.

Test Plan:
- Reset: hold reset 3 cycles while driving random serial_in -> all outputs 0, state SEARCH. Release and send 2 commas -> active stays 0.
- Lock: 4 consecutive 8'hBC MSB first -> active=1 on the edge sampling the LSB of the 4th comma; byte_stb=0 before lock.
- Misaligned start: 3 random bits, then 5 commas -> lock at the end of the 4th full comma after the boundary is found.
- ALIGN abort: BC, BC, 8'h3C, then 4×BC -> returns to SEARCH after 8'h3C; locks only after the later run.
- Data in ACTIVE: after lock send 8'hA5, 8'hBC, 8'h5A ->
  - data_out 8'hA5, valid_out=1 for 8 cycles;
  - then valid_out=0 with data_out held at 8'hA5;
  - then data_out 8'h5A, valid_out=1;
  - byte_stb pulses 3 times;
  - with PHY_RX_STATS_EN, rx_byte_count=2.
- Reset mid-symbol: in ACTIVE, assert reset after 4 bits of 8'hFF -> next edge all outputs 0, active=0; relock requires 4 fresh commas.
